// File: rtl/sha3_sponge_ctrl.sv
// SHA3 sponge sequencer: absorbs rate-wide message blocks into a 1600-bit state,
// pads the final block, drives an external keccakf_core and returns the digest.
module sha3_sponge_ctrl #(
  parameter int RATE_LANES = 9,
  parameter int OUT_BITS   = 512
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [RATE_LANES*64-1:0] i_data,
  input  logic                     i_last,
  input  logic [7:0]               i_nbytes,
  output logic                     o_kf_start,
  output logic [1599:0]            o_kf_vin,
  input  logic [1599:0]            i_kf_vout,
  input  logic                     i_kf_done,
  output logic [OUT_BITS-1:0]      o_hash,
  output logic                     o_hash_valid,
  input  logic                     i_hash_ready,
  output logic                     o_busy
);

  localparam int RATE_BYTES = RATE_LANES * 8;
  localparam int RATE_BITS  = RATE_LANES * 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_START,
    S_WAIT,
    S_PAD,
    S_OUT
  } fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [1599:0]         state_q, state_d;
  logic                  pad_pending_q, pad_pending_d;
  logic                  last_seen_q, last_seen_d;
  logic [OUT_BITS-1:0]   hash_q, hash_d;
  logic                  ready_q, start_q, hash_valid_q, busy_q;

  logic [RATE_BITS-1:0]  absorb_xor;
  logic                  last_full;
  int                    msg_len;

  // Masked block plus inline pad; a full last block defers its pad to an extra block.
  always_comb begin
    absorb_xor = '0;
    msg_len    = RATE_BYTES;
    if (i_last && ({24'd0, i_nbytes} < RATE_BYTES)) begin
      msg_len = {24'd0, i_nbytes};
    end
    last_full = (msg_len == RATE_BYTES);
    for (int k = 0; k < RATE_BYTES; k++) begin
      if (k < msg_len) begin
        absorb_xor[RATE_BITS-1-8*k -: 8] = i_data[RATE_BITS-1-8*k -: 8];
      end
    end
    if (i_last && !last_full) begin
      absorb_xor[RATE_BITS-1-8*msg_len -: 8] = absorb_xor[RATE_BITS-1-8*msg_len -: 8] ^ 8'h06;
      absorb_xor[7:0] = absorb_xor[7:0] ^ 8'h80;
    end
  end

  always_comb begin
    fsm_d         = fsm_q;
    state_d       = state_q;
    pad_pending_d = pad_pending_q;
    last_seen_d   = last_seen_q;
    hash_d        = hash_q;

    case (fsm_q)
      S_IDLE, S_ABSORB: begin
        if (i_valid && ready_q) begin
          state_d[1599 -: RATE_BITS] = state_q[1599 -: RATE_BITS] ^ absorb_xor;
          if (i_last) begin
            last_seen_d   = 1'b1;
            pad_pending_d = last_full;
          end
          fsm_d = S_START;
        end
      end
      S_START: begin
        fsm_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_kf_done) begin
          state_d = i_kf_vout;
          if (pad_pending_q) begin
            fsm_d = S_PAD;
          end else if (last_seen_q) begin
            fsm_d = S_OUT;
          end else begin
            fsm_d = S_ABSORB;
          end
        end
      end
      S_PAD: begin
        state_d[1599 -: 8] = state_q[1599 -: 8] ^ 8'h06;
        state_d[1599-8*(RATE_BYTES-1) -: 8] = state_d[1599-8*(RATE_BYTES-1) -: 8] ^ 8'h80;
        pad_pending_d = 1'b0;
        fsm_d         = S_START;
      end
      S_OUT: begin
        if (i_hash_ready) begin
          state_d     = '0;
          last_seen_d = 1'b0;
          fsm_d       = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase

    // Digest is captured once on entry so it cannot move while waiting for the consumer.
    if (fsm_d == S_OUT && fsm_q != S_OUT) begin
      hash_d = state_d[1599 -: OUT_BITS];
    end
  end

  // Outputs are registered from the next state so every one of them is low during reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q         <= S_IDLE;
      state_q       <= '0;
      pad_pending_q <= 1'b0;
      last_seen_q   <= 1'b0;
      hash_q        <= '0;
      ready_q       <= 1'b0;
      start_q       <= 1'b0;
      hash_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      pad_pending_q <= pad_pending_d;
      last_seen_q   <= last_seen_d;
      hash_q        <= hash_d;
      ready_q       <= (fsm_d == S_IDLE) || (fsm_d == S_ABSORB);
      start_q       <= (fsm_d == S_START);
      hash_valid_q  <= (fsm_d == S_OUT);
      busy_q        <= (fsm_d != S_IDLE);
    end
  end

  assign o_ready      = ready_q;
  assign o_kf_start   = start_q;
  assign o_kf_vin     = state_q;
  assign o_hash       = hash_q;
  assign o_hash_valid = hash_valid_q;
  assign o_busy       = busy_q;

endmodule
